// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage IEEE-754 style adder/subtractor.
// Flush-to-zero, four rounding modes, global stall on out_ready.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic [1:0]   round_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         error,
  output logic         inexact
);

  localparam int F = MAN_W + 4;
  localparam int LZW = $clog2(F + 1);
  localparam logic [EXP_W-1:0] EONE = '1;
  localparam logic [EXP_W-1:0] EMXF = EONE - 1'b1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EONE, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             vld;
    logic             nan;
    logic             inf;
    logic             isgn;
    logic             sgn;
    logic             esub;
    logic [1:0]       rm;
    logic [EXP_W-1:0] exp;
    logic [F-1:0]     xm;
    logic [F-1:0]     ym;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             nan;
    logic             inf;
    logic             isgn;
    logic             sgn;
    logic             esub;
    logic             zero;
    logic [1:0]       rm;
    logic [EXP_W+1:0] exp;
    logic [F-1:0]     man;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic         vld_q;
  logic [W-1:0] res_d, res_q;
  logic         ovf_d, ovf_q;
  logic         err_d, err_q;
  logic         inx_d, inx_q;
  logic         advance;

  assign advance   = out_ready || !vld_q;
  assign in_ready  = advance;
  assign out_valid = vld_q;
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign inexact   = inx_q;

  // S1: unpack, classify, order by magnitude, align Y
  logic             sa, sb, sx, sy, swap;
  logic             a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb, mx, my;
  logic [2*F-1:0]   ext;

  always_comb begin
    sa    = a[W-1];
    ea    = a[W-2:MAN_W];
    fa    = a[MAN_W-1:0];
    sb    = b[W-1] ^ sub;
    eb    = b[W-2:MAN_W];
    fb    = b[MAN_W-1:0];
    a_nan = (ea == EONE) && (fa != '0);
    b_nan = (eb == EONE) && (fb != '0);
    a_inf = (ea == EONE) && (fa == '0);
    b_inf = (eb == EONE) && (fb == '0);
    ma    = (ea == '0) ? '0 : {1'b1, fa};
    mb    = (eb == '0) ? '0 : {1'b1, fb};
    swap  = {eb, mb} > {ea, ma};
    {sx, ex, mx} = swap ? {sb, eb, mb} : {sa, ea, ma};
    {sy, ey, my} = swap ? {sa, ea, ma} : {sb, eb, mb};
    d     = ex - ey;
    ext   = {my, 3'b000, {F{1'b0}}} >> d;

    s1_d      = '0;
    s1_d.vld  = in_valid;
    s1_d.nan  = a_nan || b_nan ||
                (a_inf && b_inf && (sa != sb));
    s1_d.inf  = a_inf || b_inf;
    s1_d.isgn = a_inf ? sa : sb;
    s1_d.sgn  = sx;
    s1_d.esub = sx ^ sy;
    s1_d.rm   = round_mode;
    s1_d.exp  = ex;
    s1_d.xm   = {mx, 3'b000};
    if (32'(d) >= 32'(F - 1))
      s1_d.ym = {{(F-1){1'b0}}, |my};
    else
      s1_d.ym = ext[2*F-1:F] |
                {{(F-1){1'b0}}, |ext[F-1:0]};
  end

  // S2: add/subtract magnitudes, normalise
  logic [F:0]     sum;
  logic [LZW-1:0] lz;

  always_comb begin
    if (s1_q.esub)
      sum = {1'b0, s1_q.xm} - {1'b0, s1_q.ym};
    else
      sum = {1'b0, s1_q.xm} + {1'b0, s1_q.ym};
    lz = '0;
    for (int i = 0; i < F; i++)
      if (sum[i]) lz = LZW'(F - 1 - i);

    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.isgn = s1_q.isgn;
    s2_d.sgn  = s1_q.sgn;
    s2_d.esub = s1_q.esub;
    s2_d.rm   = s1_q.rm;
    s2_d.zero = (sum == '0);
    if (sum[F]) begin
      s2_d.man = {sum[F:2], sum[1] | sum[0]};
      s2_d.exp = {2'b00, s1_q.exp} + 1'b1;
    end else begin
      s2_d.man = sum[F-1:0] << lz;
      s2_d.exp = {2'b00, s1_q.exp} - (EXP_W+2)'(lz);
    end
  end

  // S3: round, renormalise, pack, special cases
  logic             g, r, st, lsb, inx, up;
  logic             ufl, ofl, to_inf, zsgn;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac;
  logic [EXP_W+1:0] ef;

  always_comb begin
    lsb = s2_q.man[3];
    g   = s2_q.man[2];
    r   = s2_q.man[1];
    st  = s2_q.man[0];
    inx = g || r || st;
    unique case (s2_q.rm)
      2'b00:   up = !s2_q.sgn && inx;
      2'b01:   up = s2_q.sgn && inx;
      2'b10:   up = g && (r || st || lsb);
      default: up = 1'b0;
    endcase
    rnd = {1'b0, s2_q.man[F-1:3]} + (MAN_W+2)'(up);
    if (rnd[MAN_W+1]) begin
      frac = rnd[MAN_W:1];
      ef   = s2_q.exp + 1'b1;
    end else begin
      frac = rnd[MAN_W-1:0];
      ef   = s2_q.exp;
    end
    ufl    = s2_q.exp[EXP_W+1] || (s2_q.exp == '0);
    ofl    = !ef[EXP_W+1] && (ef >= {2'b00, EONE});
    to_inf = (s2_q.rm == 2'b10) ||
             ((s2_q.rm == 2'b00) && !s2_q.sgn) ||
             ((s2_q.rm == 2'b01) && s2_q.sgn);
    zsgn   = s2_q.esub ? (s2_q.rm == 2'b01) : s2_q.sgn;

    res_d = {s2_q.sgn, ef[EXP_W-1:0], frac};
    ovf_d = 1'b0;
    err_d = 1'b0;
    inx_d = inx;
    if (s2_q.nan) begin
      res_d = QNAN;
      err_d = 1'b1;
      inx_d = 1'b0;
    end else if (s2_q.inf) begin
      res_d = {s2_q.isgn, EONE, {MAN_W{1'b0}}};
      inx_d = 1'b0;
    end else if (s2_q.zero) begin
      res_d = {zsgn, {(W-1){1'b0}}};
      inx_d = 1'b0;
    end else if (ufl) begin
      res_d = {s2_q.sgn, {(W-1){1'b0}}};
      inx_d = 1'b1;
    end else if (ofl) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      res_d = to_inf ?
        {s2_q.sgn, EONE, {MAN_W{1'b0}}} :
        {s2_q.sgn, EMXF, {MAN_W{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      vld_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (advance) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      vld_q <= s2_q.vld;
      res_q <= res_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      inx_q <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors for fp_add_pipe (binary32).
// Covers rounding, specials, stall hold and mid-flight reset.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic [1:0]  round_mode = 2'b10;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, error, inexact;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] AV [6] = '{
    32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000};
  localparam logic [31:0] EV [6] = '{
    32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000};

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .error(error), .inexact(inexact)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // one isolated op; flags are {overflow,error,inexact}
  task automatic op(input string tag,
                    input logic [31:0] av, bv,
                    input logic s, input logic [1:0] m,
                    input logic [31:0] er,
                    input logic [2:0] ef);
    int n;
    a = av; b = bv; sub = s; round_mode = m;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " lat"}, 32'(n), 32'd3);
    check({tag, " res"}, result, er);
    check({tag, " flg"},
          {29'd0, overflow, error, inexact},
          {29'd0, ef});
    @(posedge clk); #1;
  endtask

  task automatic stream();
    int  sent = 0;
    int  got = 0;
    bit  acc;
    for (int c = 0; c < 40; c++) begin
      out_ready  = !(c >= 4 && c < 9);
      in_valid   = (sent < 6);
      a          = (sent < 6) ? AV[sent] : '0;
      b          = ONE;
      sub        = 1'b0;
      round_mode = 2'b10;
      #4;
      if (out_valid && !out_ready) begin
        check("stall rdy", {31'd0, in_ready}, 32'd0);
        check("stall hold", result,
              (got < 6) ? EV[got] : 32'hFFFFFFFF);
      end
      if (out_valid && out_ready) begin
        check("stream res", result,
              (got < 6) ? EV[got] : 32'hFFFFFFFF);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream cnt", 32'(got), 32'd6);
  endtask

  initial begin
    bit stale;
    #12;
    check("rst ov", {31'd0, out_valid}, 32'd0);
    check("rst res", result, 32'd0);
    check("rst rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("1+2", ONE, 32'h40000000, 0, 2'b10,
       32'h40400000, 3'b000);
    op("tie rne", ONE, 32'h33800000, 0, 2'b10,
       32'h3F800000, 3'b001);
    op("tie rup", ONE, 32'h33800000, 0, 2'b00,
       32'h3F800001, 3'b001);
    op("tie rtz", ONE, 32'h33800000, 0, 2'b11,
       32'h3F800000, 3'b001);
    op("ovf rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b10,
       32'h7F800000, 3'b101);
    op("ovf rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b11,
       32'h7F7FFFFF, 3'b101);
    op("novf up", 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'b00,
       32'hFF7FFFFF, 3'b101);
    op("novf dn", 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'b01,
       32'hFF800000, 3'b101);
    op("inf-inf", 32'h7F800000, 32'hFF800000, 0, 2'b10,
       32'h7FC00000, 3'b010);
    op("2-2 rdn", 32'h40000000, 32'h40000000, 1, 2'b01,
       32'h80000000, 3'b000);
    op("2-2 rne", 32'h40000000, 32'h40000000, 1, 2'b10,
       32'h00000000, 3'b000);
    op("-0+-0", 32'h80000000, 32'h80000000, 0, 2'b10,
       32'h80000000, 3'b000);
    op("inf+1", 32'h7F800000, ONE, 0, 2'b10,
       32'h7F800000, 3'b000);
    op("nan in", 32'h7FC00001, ONE, 0, 2'b10,
       32'h7FC00000, 3'b010);
    op("subn in", 32'h00000001, ONE, 0, 2'b10,
       ONE, 3'b000);
    op("uflow", 32'h00800001, 32'h00800000, 1, 2'b10,
       32'h00000000, 3'b001);
    op("1-ulp", ONE, 32'h33800000, 1, 2'b10,
       32'h3F7FFFFF, 3'b000);
    op("rnd carry", 32'h3FFFFFFF, 32'h33800000, 0, 2'b10,
       32'h40000000, 3'b001);

    stream();
    @(posedge clk); #1;

    a = ONE; b = ONE; sub = 1'b0; round_mode = 2'b10;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre rst ov", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst ov", {31'd0, out_valid}, 32'd0);
    check("mid rst res", result, 32'd0);
    check("mid rst rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("no stale", {31'd0, stale}, 32'd0);
    op("post rst", 32'h40000000, ONE, 0, 2'b10,
       32'h40400000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL: parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 SHALL: parameter MAN_W, default 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL: in_valid  input  1  operand set presented.
REQ-006 SHALL: in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL: a, b  input  W each  IEEE-754-format operands.
REQ-008 SHALL: sub  input  1  1 = compute a-b (b sign inverted), 0 = a+b.
REQ-009 SHALL: round_mode  input  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 toward zero; captured with operands.
REQ-010 SHALL: out_valid  output  1  result presented.
REQ-011 SHALL: out_ready  input  1  consumer accepts result.
REQ-012 SHALL: result  output  W  rounded sum.
REQ-013 SHALL: overflow  output  1  finite result exceeded max finite magnitude.
REQ-014 SHALL: error  output  1  invalid operation or NaN input.
REQ-015 SHALL: inexact  output  1  rounding discarded nonzero bits.

Function
REQ-016 SHALL: 3-stage pipeline -- S1 unpack/special detect/swap so |X|>=|Y|/align; S2 add or subtract, leading-zero normalise; S3 round, renormalise, pack.
REQ-017 SHALL: transfer in on in_valid&&in_ready, out on out_valid&&out_ready; latency exactly 3 cycles with no stall; throughput 1/cycle.
REQ-018 SHALL: global stall: advance = out_ready || !out_valid; in_ready = advance; no stage register changes while advance=0.
REQ-019 SHALL: result, overflow, error, inexact held stable while out_valid=1 and out_ready=0; results emerge in acceptance order, none dropped or duplicated.
REQ-020 SHALL: bubbles (in_valid=0 on advance) propagate as invalid stages; out_valid=0 never signals a result.
REQ-021 SHALL: alignment keeps guard, round and sticky bits; shift >= MAN_W+3 reduces Y to sticky only.
REQ-022 SHALL: nearest-even rounds up when G&&(R||S||LSB); +inf mode rounds up magnitude when positive and G|R|S; -inf mode likewise when negative; zero mode truncates.
REQ-023 SHALL: mantissa carry-out from rounding increments exponent and shifts right one.
REQ-024 SHALL: subnormal inputs treated as signed zero; results below min normal flushed to signed zero with inexact=1.
REQ-025 SHALL: exact-zero result from opposite signs is +0, except -0 in round_mode 01; (-0)+(-0) = -0.
REQ-026 SHALL: any NaN input, or inf plus opposite-sign inf, yields canonical NaN {0, all-ones exp, MSB fraction 1, rest 0}, error=1, other flags 0.
REQ-027 SHALL: single inf operand (or same-sign infs) yields that inf, all flags 0.
REQ-028 SHALL: overflow: overflow=1, inexact=1; result inf for nearest-even; max finite for toward zero; toward +inf gives +inf or -max finite; toward -inf gives -inf or +max finite.
REQ-029 SHALL: error and overflow never both 1.

Reset
REQ-030 SHALL: rst_n=0 asynchronously clears all stage valids; out_valid=0, result=0, overflow=0, error=0, inexact=0 while in reset.
REQ-031 SHALL: in-flight operations discarded on reset; first result after release only from operands accepted after release.
REQ-032 SHALL: in_ready=1 during and after reset (out_valid=0).

Verification
REQ-033 SHALL: a=0x3F800000, b=0x40000000, sub=0, mode 10 -> result 0x40400000 three cycles later, flags 0.
REQ-034 SHALL: a=0x3F800000, b=0x33800000 (tie) -> mode 10 0x3F800000, mode 00 0x3F800001, mode 11 0x3F800000; inexact=1 each.
REQ-035 SHALL: a=b=0x7F7FFFFF -> mode 10 0x7F800000 overflow=1; mode 11 0x7F7FFFFF overflow=1.
REQ-036 SHALL: a=0x7F800000, b=0xFF800000 -> 0x7FC00000 error=1; a=0x40000000, b=0x40000000, sub=1, mode 01 -> 0x80000000.
REQ-037 SHALL: stream 6 operand sets, out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled, outputs held, all 6 results in order.
REQ-038 SHALL: rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, no stale result after release.
